alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 1: cycles each vector is held on the ALU inputs before the checking cycle (legal 1..15).
REQ-002 SHALL provide ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a self-test run (sampled in IDLE or DONE only).
- seed  in  8  operand generator seed, sampled on accepted start.
- num_vectors  in  8  vectors per opcode, sampled on accepted start; 0 means 256.
- alu_a  out  8  operand a to ALU.
- alu_b  out  8  operand b to ALU.
- alu_cnt  out  3  ALU opcode.
- alu_c  in  8  ALU result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  run in progress.
- done  out  1  run complete, held until next accepted start or reset.
- pass  out  1  done and err_count == 0.
- err_count  out  8  mismatching checks, saturating at 255.
- first_fail_op  out  3  opcode of first mismatch.
- first_fail_a  out  8  operand a of first mismatch.
- first_fail_b  out  8  operand b of first mismatch.

Function
REQ-003 SHALL use reference model, all arithmetic mod 256: 0 ADD a+b; 1 SUB a-b; 2 NOT ~a; 3 SHL a<<b; 4 SHR a>>b (logical; shift >= 8 gives 0); 5 AND a&b; 6 OR a|b; 7 SLT (a<b unsigned) ? 1 : 0; expected zero = (expected c == 0).
REQ-004 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-005 IDLE/DONE + start=1 SHALL, on that edge: enter DRIVE, set busy=1, clear done/pass/err_count/first_fail_*, set opcode 0, vector index 0, load 16-bit LFSR with {seed, ~seed}.
REQ-006 start while in DRIVE or CHECK SHALL be ignored.
REQ-007 Vector operands: index 0 = (8'h00, 8'h00); index 1 = (8'hFF, 8'h01); index >= 2 = (lfsr[15:8], lfsr[7:0]).
REQ-008 LFSR SHALL be Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advancing one step per completed vector of index >= 2 only; never reloaded within a run.
REQ-009 alu_a/alu_b/alu_cnt SHALL be registered and stable for SETTLE_CYCLES cycles in DRIVE plus 1 cycle in CHECK.
REQ-010 Comparison SHALL occur on the edge ending CHECK; mismatch = (alu_c != expected c) or (alu_zero != expected zero).
REQ-011 On mismatch: err_count increments unless 255; first_fail_* captured only when err_count was 0.
REQ-012 After CHECK: next vector index; after last index, next opcode with index 0; after opcode 7 last index, enter DONE.
REQ-013 Run length SHALL be exactly 8 * N * (SETTLE_CYCLES + 1) cycles of busy=1, N = num_vectors (256 if 0).
REQ-014 DONE: busy=0, done=1, pass=(err_count==0); alu_a/alu_b/alu_cnt hold last values; results hold until accepted start or reset.
REQ-015 pass SHALL be 0 whenever done=0.

Reset
REQ-016 reset=1 SHALL on the next edge force IDLE and all outputs to 0, including mid-run; reset has priority over start.
REQ-017 Runs SHALL be deterministic: identical seed/num_vectors/ALU give identical outputs.

Verification
REQ-018 Reset: assert reset 2 cycles with start=1 -> all outputs 0, busy=0, state IDLE.
REQ-019 Golden ALU, seed=8'h3C, num_vectors=4, SETTLE_CYCLES=1 -> busy exactly 64 cycles, then done=1, pass=1, err_count=0; start pulses mid-run change nothing.
REQ-020 ALU with alu_c bit 0 stuck at 1, num_vectors=2 -> first_fail_op=0, first_fail_a=8'h00, first_fail_b=8'h00, pass=0, err_count equals model-predicted count.
REQ-021 Golden ALU, num_vectors=0 -> busy exactly 4096 cycles, pass=1.
REQ-022 ALU with alu_zero inverted, num_vectors=0 -> err_count=255 (saturated), first_fail_op=0, first_fail_a=first_fail_b=8'h00.
REQ-023 reset asserted on cycle 10 of a run -> all outputs 0 next edge; rerun with same seed -> results identical to an uninterrupted run.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for an 8-bit, 8-opcode ALU.
// The block drives registered operands and an opcode into the ALU. It holds
// each vector for SETTLE_CYCLES cycles, then checks the result for one
// cycle. It counts mismatches and records the first failing vector.
module alu_bist #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] seed,
   input  logic [7:0] num_vectors,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_cnt,
   input  logic [7:0] alu_c,
   input  logic       alu_zero,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [2:0] first_fail_op,
   output logic [7:0] first_fail_a,
   output logic [7:0] first_fail_b
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  settle_cnt;
   logic [7:0]  vec_idx;
   logic [7:0]  last_idx;     // num_vectors-1; 0 wraps to 255, giving 256 vectors
   logic [15:0] lfsr;
   logic [15:0] lfsr_step;
   logic [15:0] lfsr_adv;     // LFSR value after completing the current vector
   logic [7:0]  exp_c;
   logic        exp_zero;
   logic        mismatch;
   logic        accept;
   logic        settled;
   logic        last_vec;
   logic        last_run;

   assign accept    = start && (state == S_IDLE || state == S_DONE);
   assign settled   = (settle_cnt == SETTLE_LAST);
   assign last_vec  = (vec_idx == last_idx);
   assign last_run  = last_vec && (alu_cnt == 3'd7);
   assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   // Only random vectors (index >= 2) consume an LFSR step
   assign lfsr_adv  = (vec_idx >= 8'd2) ? lfsr_step : lfsr;

   // Reference ALU, evaluated on the operands currently held on the ALU inputs
   always_comb begin
      exp_c = 8'd0;
      case (alu_cnt)
         3'd0: exp_c = alu_a + alu_b;
         3'd1: exp_c = alu_a - alu_b;
         3'd2: exp_c = ~alu_a;
         3'd3: exp_c = alu_a << alu_b;   // shifts of 8 or more yield 0
         3'd4: exp_c = alu_a >> alu_b;
         3'd5: exp_c = alu_a & alu_b;
         3'd6: exp_c = alu_a | alu_b;
         3'd7: exp_c = {7'd0, alu_a < alu_b};
         default: exp_c = 8'd0;
      endcase
      exp_zero = (exp_c == 8'd0);
      mismatch = (alu_c != exp_c) || (alu_zero != exp_zero);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start)   state_nxt = S_DRIVE;
         S_DRIVE:        if (settled) state_nxt = S_CHECK;
         S_CHECK:        state_nxt = last_run ? S_DONE : S_DRIVE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // FSM status outputs; pass can only be high while done is high
   always_comb begin
      busy = (state == S_DRIVE) || (state == S_CHECK);
      done = (state == S_DONE);
      pass = done && (err_count == 8'd0);
   end

   // Datapath: vector sequencing, operand drive and result bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a         <= 8'd0;
         alu_b         <= 8'd0;
         alu_cnt       <= 3'd0;
         vec_idx       <= 8'd0;
         last_idx      <= 8'd0;
         lfsr          <= 16'd0;
         settle_cnt    <= 4'd0;
         err_count     <= 8'd0;
         first_fail_op <= 3'd0;
         first_fail_a  <= 8'd0;
         first_fail_b  <= 8'd0;
      end else if (accept) begin
         alu_a         <= 8'd0;
         alu_b         <= 8'd0;
         alu_cnt       <= 3'd0;
         vec_idx       <= 8'd0;
         last_idx      <= num_vectors - 8'd1;
         lfsr          <= {seed, ~seed};
         settle_cnt    <= 4'd0;
         err_count     <= 8'd0;
         first_fail_op <= 3'd0;
         first_fail_a  <= 8'd0;
         first_fail_b  <= 8'd0;
      end else if (state == S_DRIVE) begin
         settle_cnt <= settled ? 4'd0 : settle_cnt + 4'd1;
      end else if (state == S_CHECK) begin
         if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0) begin
               first_fail_op <= alu_cnt;
               first_fail_a  <= alu_a;
               first_fail_b  <= alu_b;
            end
         end
         lfsr <= lfsr_adv;
         // On the final vector the operands stay frozen for inspection in DONE
         if (!last_run) begin
            if (last_vec) begin
               vec_idx <= 8'd0;
               alu_cnt <= alu_cnt + 3'd1;
               alu_a   <= 8'd0;
               alu_b   <= 8'd0;
            end else begin
               vec_idx <= vec_idx + 8'd1;
               if (vec_idx == 8'd0) begin
                  alu_a <= 8'hFF;
                  alu_b <= 8'h01;
               end else begin
                  alu_a <= lfsr_adv[15:8];
                  alu_b <= lfsr_adv[7:0];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: runs the BIST against a behavioural ALU with selectable faults.
// A high-level model enumerates every vector of the run to predict the results.
module tb_alu_bist;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] seed, num_vectors;
   logic [7:0] alu_a, alu_b, alu_c;
   logic [2:0] alu_cnt;
   logic       alu_zero, busy, done, pass;
   logic [7:0] err_count, first_fail_a, first_fail_b;
   logic [2:0] first_fail_op;

   int n_chk  = 0;
   int n_fail = 0;
   int fault  = 0;   // 0 golden, 1 c[0] stuck 1, 2 zero inverted, 3 c[7] flipped on odd a^b

   always #5 clk = ~clk;

   alu_bist #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .num_vectors(num_vectors),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cnt(alu_cnt), .alu_c(alu_c), .alu_zero(alu_zero),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail_op(first_fail_op), .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
   );

   function automatic int ref_alu(input int op, input int a, input int b);
      case (op)
         0: return (a + b) & 255;
         1: return (a - b) & 255;
         2: return (~a) & 255;
         3: return (b >= 8) ? 0 : ((a << b) & 255);
         4: return (b >= 8) ? 0 : (a >> b);
         5: return a & b;
         6: return a | b;
         default: return (a < b) ? 1 : 0;
      endcase
   endfunction

   function automatic int fab_c(input int flt, input int op, input int a, input int b);
      int r;
      r = ref_alu(op, a, b);
      if (flt == 1) r = r | 1;
      if (flt == 3 && (((a ^ b) & 1) == 1)) r = r ^ 128;
      return r;
   endfunction

   function automatic int fab_z(input int flt, input int op, input int a, input int b);
      int z;
      z = (ref_alu(op, a, b) == 0) ? 1 : 0;
      if (flt == 2) z = 1 - z;
      return z;
   endfunction

   // Device under self-test: a combinational ALU with an optional planted defect
   always_comb begin
      alu_c    = 8'(fab_c(fault, int'(alu_cnt), int'(alu_a), int'(alu_b)));
      alu_zero = fab_z(fault, int'(alu_cnt), int'(alu_a), int'(alu_b)) != 0;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Enumerate the whole run: opcode-major, fixed first two vectors, then LFSR operands
   task automatic model(input int sd, input int nv, input int flt,
                        output int e_err, output int e_op, output int e_a, output int e_b,
                        output int l_op, output int l_a, output int l_b);
      int n, l, a, b, ex, fb;
      n = (nv == 0) ? 256 : nv;
      l = ((sd & 255) << 8) | ((~sd) & 255);
      e_err = 0; e_op = 0; e_a = 0; e_b = 0; l_op = 0; l_a = 0; l_b = 0;
      for (int op = 0; op < 8; op++) begin
         for (int i = 0; i < n; i++) begin
            if (i == 0)      begin a = 0;      b = 0;       end
            else if (i == 1) begin a = 255;    b = 1;       end
            else             begin a = l >> 8; b = l & 255; end
            ex = ref_alu(op, a, b);
            if (fab_c(flt, op, a, b) != ex || fab_z(flt, op, a, b) != ((ex == 0) ? 1 : 0)) begin
               if (e_err == 0) begin e_op = op; e_a = a; e_b = b; end
               if (e_err < 255) e_err++;
            end
            if (i >= 2) begin
               fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
               l  = ((l << 1) | fb) & 16'hFFFF;
            end
            l_op = op; l_a = a; l_b = b;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_ops"}, {alu_cnt, alu_a, alu_b}, 0);
      chk({tag, "_ff"}, {first_fail_op, first_fail_a, first_fail_b}, 0);
   endtask

   task automatic do_run(input string tag, input int sd, input int nv, input int flt, input bit poke);
      int n, cyc, pviol, e_err, e_op, e_a, e_b, l_op, l_a, l_b;
      model(sd, nv, flt, e_err, e_op, e_a, e_b, l_op, l_a, l_b);
      n = (nv == 0) ? 256 : nv;
      @(negedge clk);
      fault = flt; seed = 8'(sd); num_vectors = 8'(nv); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // inputs are only sampled on the accepting edge
      seed = 8'($urandom); num_vectors = 8'($urandom);
      cyc = 0; pviol = 0;
      while (busy && cyc < 5000) begin
         cyc++;
         if (pass || done) pviol++;
         start = poke && (cyc % 7 == 3);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_busy_cycles"}, cyc, 8 * n * 2);
      chk({tag, "_pass_while_busy"}, pviol, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_pass"}, pass, (e_err == 0) ? 1 : 0);
      chk({tag, "_err"}, err_count, e_err);
      chk({tag, "_ff_op"}, first_fail_op, e_op);
      chk({tag, "_ff_a"}, first_fail_a, e_a);
      chk({tag, "_ff_b"}, first_fail_b, e_b);
      chk({tag, "_last_vec"}, {alu_cnt, alu_a, alu_b}, (l_op << 16) | (l_a << 8) | l_b);
      repeat (3) @(negedge clk);
      chk({tag, "_hold"}, {done, err_count, first_fail_a}, (1 << 16) | (e_err << 8) | e_a);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sd, nv, flt;
      reset = 1'b1; start = 1'b1; seed = 8'h5A; num_vectors = 8'd3;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk_zero("idle");

      do_run("golden4", 8'h3C, 4, 0, 1'b1);
      do_run("stuck0", $urandom_range(0, 255), 2, 1, 1'b0);
      do_run("golden256", $urandom_range(0, 255), 0, 0, 1'b0);
      do_run("zinv256", $urandom_range(0, 255), 0, 2, 1'b0);

      for (int k = 0; k < 5; k++) begin
         sd  = $urandom_range(0, 255);
         nv  = $urandom_range(1, 24);
         flt = $urandom_range(0, 3);
         do_run($sformatf("rnd%0d", k), sd, nv, flt, k[0]);
      end

      // Reset on cycle 10 of a run, then repeat the same run to completion
      sd = $urandom_range(0, 255);
      @(negedge clk);
      fault = 3; seed = 8'(sd); num_vectors = 8'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("midreset");
      reset = 1'b0;
      do_run("rerun", sd, 6, 3, 1'b0);
      do_run("rerun2", sd, 6, 3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
